// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a three-source register-file write port with a
// pending-write scoreboard and a registered single-cycle write stage.
module regfile_wb_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [4:0]  req_addr0,
  input  logic [4:0]  req_addr1,
  input  logic [4:0]  req_addr2,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  output logic [2:0]  grant,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic [31:0] busy,
  output logic        enable_reg_write,
  output logic [4:0]  addr_write,
  output logic [31:0] write_data
);

  logic [1:0]  last_r;
  logic [31:0] busy_r;
  logic        en_r;
  logic [4:0]  addr_r;
  logic [31:0] data_r;

  logic [2:0]  grant_s;
  logic [4:0]  sel_addr_s;
  logic [31:0] sel_data_s;
  logic [1:0]  sel_idx_s;
  logic        xfer_s;
  logic        wr_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;
  logic [31:0] busy_nxt_s;

  // Search starts at the requester after the last one granted.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      2'd0: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else           g = 3'b000;
      end
      2'd1: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else           g = 3'b000;
      end
      default: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else           g = 3'b000;
      end
    endcase
    return g;
  endfunction

  function automatic logic [2:0] fixed_pick(input logic [2:0] v);
    logic [2:0] g;
    if (v[0])      g = 3'b001;
    else if (v[1]) g = 3'b010;
    else if (v[2]) g = 3'b100;
    else           g = 3'b000;
    return g;
  endfunction

  // Grant selection; forced idle while reset is held.
  always_comb begin
    grant_s = 3'b000;
    if (!reset) begin
      grant_s = 3'b000;
    end else if (RR_ENABLE) begin
      grant_s = rr_pick(req_valid, last_r);
    end else begin
      grant_s = fixed_pick(req_valid);
    end
  end

  assign grant = grant_s;

  // Route the granted requester's address and data to the write stage.
  always_comb begin
    sel_addr_s = 5'd0;
    sel_data_s = 32'd0;
    sel_idx_s  = last_r;
    case (grant_s)
      3'b001: begin
        sel_addr_s = req_addr0;
        sel_data_s = req_data0;
        sel_idx_s  = 2'd0;
      end
      3'b010: begin
        sel_addr_s = req_addr1;
        sel_data_s = req_data1;
        sel_idx_s  = 2'd1;
      end
      3'b100: begin
        sel_addr_s = req_addr2;
        sel_data_s = req_data2;
        sel_idx_s  = 2'd2;
      end
      default: begin
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        sel_idx_s  = last_r;
      end
    endcase
  end

  assign xfer_s = ((grant_s & req_valid) != 3'b000);
  assign wr_s   = xfer_s && (sel_addr_s != 5'd0);

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  assign clr_mask_s = wr_s ? (32'd1 << sel_addr_s) : 32'd0;
  assign set_mask_s = (issue_valid && (issue_addr != 5'd0)) ? (32'd1 << issue_addr) : 32'd0;
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // Write stage, scoreboard and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r   <= 1'b0;
      addr_r <= 5'd0;
      data_r <= 32'd0;
      busy_r <= 32'd0;
      last_r <= 2'd2;
    end else begin
      en_r   <= wr_s;
      busy_r <= busy_nxt_s;
      if (wr_s) begin
        addr_r <= sel_addr_s;
        data_r <= sel_data_s;
      end
      if (xfer_s) begin
        last_r <= sel_idx_s;
      end
    end
  end

  assign enable_reg_write = en_r;
  assign addr_write       = addr_r;
  assign write_data       = data_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomised bench for regfile_wb_arbiter: a reference model predicts
// grants, queues expected writes and compares them when the write stage updates.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [4:0]  raddr [3];
  logic [31:0] rdata [3];
  logic        issue_valid;
  logic [4:0]  issue_addr;

  logic [2:0]  grant_rr, grant_fp;
  logic [31:0] busy_rr, busy_fp;
  logic        en_rr, en_fp;
  logic [4:0]  aw_rr, aw_fp;
  logic [31:0] wd_rr, wd_fp;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic [31:0] m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  exp_t        sbq[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(raddr[0]), .req_addr1(raddr[1]), .req_addr2(raddr[2]),
    .req_data0(rdata[0]), .req_data1(rdata[1]), .req_data2(rdata[2]),
    .grant(grant_rr), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy(busy_rr), .enable_reg_write(en_rr), .addr_write(aw_rr), .write_data(wd_rr)
  );

  regfile_wb_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(raddr[0]), .req_addr1(raddr[1]), .req_addr2(raddr[2]),
    .req_data0(rdata[0]), .req_data1(rdata[1]), .req_data2(rdata[2]),
    .grant(grant_fp), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy(busy_fp), .enable_reg_write(en_fp), .addr_write(aw_fp), .write_data(wd_fp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_rr(input logic [2:0] v, input int ptr);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (v[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  function automatic logic [2:0] model_fp(input logic [2:0] v);
    for (int i = 0; i < 3; i++) begin
      if (v[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_ptr  = 2;
    m_busy = 32'd0;
    m_addr = 5'd0;
    m_data = 32'd0;
    sbq.delete();
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    logic [2:0] eg;
    int         sel;
    exp_t       e;
    #1;
    eg = model_rr(req_valid, m_ptr);
    chk({tag, "_grant_rr"}, {29'd0, grant_rr}, {29'd0, eg});
    chk({tag, "_grant_fp"}, {29'd0, grant_fp}, {29'd0, model_fp(req_valid)});
    if (eg != 3'b000) begin
      sel = (eg == 3'b001) ? 0 : ((eg == 3'b010) ? 1 : 2);
      if (raddr[sel] != 5'd0) begin
        m_addr = raddr[sel];
        m_data = rdata[sel];
        m_busy[raddr[sel]] = 1'b0;
      end
      sbq.push_back('{en: (raddr[sel] != 5'd0), addr: m_addr, data: m_data});
      m_ptr = sel;
    end
    if (issue_valid && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
    end else begin
      e = '{en: 1'b0, addr: m_addr, data: m_data};
    end
    chk({tag, "_en"},   {31'd0, en_rr}, {31'd0, e.en});
    chk({tag, "_addr"}, {27'd0, aw_rr}, {27'd0, e.addr});
    chk({tag, "_data"}, wd_rr, e.data);
    chk({tag, "_busy"}, busy_rr, m_busy);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 3'b111;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    raddr[0] = 5'd1;  rdata[0] = 32'h1111_0001;
    raddr[1] = 5'd2;  rdata[1] = 32'h2222_0002;
    raddr[2] = 5'd3;  rdata[2] = 32'h3333_0003;
    model_reset();

    // Reset state and grant suppression under reset.
    #13;
    chk("rst_grant_rr", {29'd0, grant_rr}, 32'd0);
    chk("rst_grant_fp", {29'd0, grant_fp}, 32'd0);
    chk("rst_en",   {31'd0, en_rr}, 32'd0);
    chk("rst_addr", {27'd0, aw_rr}, 32'd0);
    chk("rst_data", wd_rr, 32'd0);
    chk("rst_busy", busy_rr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // All requesters held: 001, 010, 100, 001 with a write every cycle.
    for (int i = 0; i < 4; i++) step("rr_all");
    chk("rr_ptr_after4", {30'd0, 2'(m_ptr)}, 32'd0);

    // Single write to x5 then an idle cycle with held address/data.
    req_valid = 3'b001; raddr[0] = 5'd5; rdata[0] = 32'hDEAD_BEEF;
    step("w5");
    req_valid = 3'b000;
    step("w5_idle");

    // Address-0 request is consumed without a write; busy untouched.
    issue_valid = 1'b1; issue_addr = 5'd9;
    step("issue9");
    issue_valid = 1'b0;
    req_valid = 3'b010; raddr[1] = 5'd0; rdata[1] = 32'h0000_0001;
    step("x0");
    req_valid = 3'b000;
    step("x0_idle");

    // Fixed priority never serves req2 while req1 is pending.
    req_valid = 3'b110; raddr[1] = 5'd10; raddr[2] = 5'd11;
    for (int i = 0; i < 4; i++) step("fp_110");
    req_valid = 3'b000;

    // Same-cycle issue and write to x7 leaves it pending; next write clears it.
    issue_valid = 1'b1; issue_addr = 5'd7;
    step("issue7");
    req_valid = 3'b001; raddr[0] = 5'd7; rdata[0] = 32'h0000_0777;
    step("issue7_and_wr7");
    chk("busy7_kept", {31'd0, busy_rr[7]}, 32'd1);
    issue_valid = 1'b0; rdata[0] = 32'h0000_0778;
    step("wr7");
    chk("busy7_clear", {31'd0, busy_rr[7]}, 32'd0);
    req_valid = 3'b000; issue_valid = 1'b1; issue_addr = 5'd12;
    step("issue12a");
    step("issue12b");
    issue_valid = 1'b0; req_valid = 3'b100; raddr[2] = 5'd12;
    step("wr12");
    issue_valid = 1'b1; issue_addr = 5'd0; req_valid = 3'b000;
    step("issue0");

    // Randomised back-to-back traffic.
    for (int i = 0; i < 30; i++) begin
      req_valid   = 3'($urandom_range(0, 7));
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 5'($urandom_range(0, 31));
      for (int j = 0; j < 3; j++) begin
        raddr[j] = 5'($urandom_range(0, 31));
        rdata[j] = $urandom;
      end
      step("rand");
    end

    // Asynchronous reset mid-cycle drops the in-flight write and scoreboard.
    issue_valid = 1'b1; issue_addr = 5'd3;
    req_valid = 3'b001; raddr[0] = 5'd4; rdata[0] = 32'h4444_0004;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", busy_rr, 32'd0);
    chk("async_en",   {31'd0, en_rr}, 32'd0);
    chk("async_addr", {27'd0, aw_rr}, 32'd0);
    chk("async_grant_rr", {29'd0, grant_rr}, 32'd0);
    chk("async_grant_fp", {29'd0, grant_fp}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1; issue_valid = 1'b0; req_valid = 3'b000;
    step("post_rst_idle");
    req_valid = 3'b011; raddr[1] = 5'd6;
    step("post_rst_req");
    chk("post_rst_first_req0", {31'd0, sbq.size() == 0 && aw_rr == 5'd4}, 32'd1);
    req_valid = 3'b000;
    step("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
